// File: rtl/noc_bfm_pkg.sv
// Shared types and helpers for the NoC BFM traffic blocks and the port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package noc_bfm_pkg;

    // Width of the source id carried by TPG words; grant indices must fit in it.
    localparam int ARB_ID_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // $clog2 that never returns 0, so one-entry/two-entry indices still get a bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority first-set-bit search: lowest index at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;

    always_comb begin
        int c;
        c   = 0;
        dbl = {req, req};
        rot = NUM_REQ'(dbl >> ptr);
        any = |req;
        idx = '0;
        // Walk downwards so the candidate closest to ptr overwrites the others.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                c = int'(ptr) + k;
                if (c >= NUM_REQ) begin
                    c = c - NUM_REQ;
                end
                idx = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/noc_port_arbiter.sv
// Shares one router injection port between NUM_REQ sources, round-robin with bounded bursts.
// Latency: 1 cycle from accept to out_valid_out.
// Backpressure: out_ready_in low with a held word freezes outputs and drops every req_ready_out.
module noc_port_arbiter
    import noc_bfm_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int WIDTH        = 32,
    parameter int N            = 16,
    parameter int N_ADDR_WIDTH = $clog2(N),
    parameter int MAX_BURST    = 2,
    parameter int REQ_IDX_W    = clog2_min1(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ*WIDTH-1:0]        req_data_in,
    input  logic [NUM_REQ*N_ADDR_WIDTH-1:0] req_dest_in,
    input  logic [NUM_REQ-1:0]              req_valid_in,
    output logic [NUM_REQ-1:0]              req_ready_out,
    output logic [WIDTH-1:0]                out_data_out,
    output logic [N_ADDR_WIDTH-1:0]         out_dest_out,
    output logic                            out_valid_out,
    input  logic                            out_ready_in,
    output logic [REQ_IDX_W-1:0]            grant_idx_out
);

    localparam int CNT_W = clog2_min1(MAX_BURST + 1);

    arb_state_t           state, state_nxt;
    logic [REQ_IDX_W-1:0] owner, owner_nxt;
    logic [REQ_IDX_W-1:0] ptr, ptr_nxt;
    logic [CNT_W-1:0]     burst_cnt, burst_cnt_nxt;

    logic                 load_en;
    logic                 any_valid;
    logic                 owner_ok;
    logic                 accept;
    logic [REQ_IDX_W-1:0] rr_idx;
    logic [REQ_IDX_W-1:0] sel;

    logic [WIDTH-1:0]        data_arr [NUM_REQ];
    logic [N_ADDR_WIDTH-1:0] dest_arr [NUM_REQ];

    function automatic logic [REQ_IDX_W-1:0] wrap_inc(input logic [REQ_IDX_W-1:0] i);
        return (i == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : i + REQ_IDX_W'(1);
    endfunction

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (REQ_IDX_W)
    ) u_pick (
        .req (req_valid_in),
        .ptr (ptr),
        .any (any_valid),
        .idx (rr_idx)
    );

    assign load_en  = !out_valid_out || out_ready_in;
    assign owner_ok = (state == BURST) && req_valid_in[owner] &&
                      (burst_cnt < CNT_W'(MAX_BURST));
    assign sel      = owner_ok ? owner : rr_idx;
    assign accept   = load_en && any_valid;

    always_comb begin
        req_ready_out = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready_out[i] = accept && (sel == REQ_IDX_W'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = req_data_in[i*WIDTH +: WIDTH];
            dest_arr[i] = req_dest_in[i*N_ADDR_WIDTH +: N_ADDR_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            ptr       <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            ptr       <= ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        ptr_nxt       = ptr;
        burst_cnt_nxt = burst_cnt;
        if (accept) begin
            if (owner_ok) begin
                if ((burst_cnt + CNT_W'(1)) < CNT_W'(MAX_BURST)) begin
                    burst_cnt_nxt = burst_cnt + CNT_W'(1);
                end else begin
                    state_nxt     = IDLE;
                    ptr_nxt       = wrap_inc(owner);
                    burst_cnt_nxt = '0;
                end
            end else begin
                // New owner: either from IDLE or because the old owner went quiet.
                owner_nxt = sel;
                if (MAX_BURST > 1) begin
                    state_nxt     = BURST;
                    burst_cnt_nxt = CNT_W'(1);
                end else begin
                    state_nxt     = IDLE;
                    ptr_nxt       = wrap_inc(sel);
                    burst_cnt_nxt = '0;
                end
            end
        end else if (load_en && (state == BURST)) begin
            state_nxt     = IDLE;
            ptr_nxt       = wrap_inc(owner);
            burst_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_out <= 1'b0;
            out_data_out  <= '0;
            out_dest_out  <= '0;
            grant_idx_out <= '0;
        end else if (accept) begin
            out_valid_out <= 1'b1;
            out_data_out  <= data_arr[sel];
            out_dest_out  <= dest_arr[sel];
            grant_idx_out <= sel;
        end else if (load_en) begin
            out_valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Directed bench for noc_port_arbiter: vector table plus hand-written backpressure and reset sequences.
module tb_noc_port_arbiter;
    import noc_bfm_pkg::*;

    localparam int NUM_REQ   = 4;
    localparam int WIDTH     = 32;
    localparam int N         = 16;
    localparam int AW        = 4;
    localparam int MAX_BURST = 2;

    logic                    clk;
    logic                    rst;
    logic [NUM_REQ*WIDTH-1:0] req_data_in;
    logic [NUM_REQ*AW-1:0]   req_dest_in;
    logic [NUM_REQ-1:0]      req_valid_in;
    logic [NUM_REQ-1:0]      req_ready_out;
    logic [WIDTH-1:0]        out_data_out;
    logic [AW-1:0]           out_dest_out;
    logic                    out_valid_out;
    logic                    out_ready_in;
    logic [1:0]              grant_idx_out;

    noc_port_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .WIDTH     (WIDTH),
        .N         (N),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_data_in   (req_data_in),
        .req_dest_in   (req_dest_in),
        .req_valid_in  (req_valid_in),
        .req_ready_out (req_ready_out),
        .out_data_out  (out_data_out),
        .out_dest_out  (out_dest_out),
        .out_valid_out (out_valid_out),
        .out_ready_in  (out_ready_in),
        .grant_idx_out (grant_idx_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] data_c [NUM_REQ];
    logic [AW-1:0]    dest_c [NUM_REQ];

    typedef struct {
        logic       do_rst;
        logic [3:0] v;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [1:0] exp_g;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rs, input logic [3:0] v, input logic ordy,
                       input logic [3:0] rdy, input logic ov, input logic [1:0] g);
        vec_t r;
        r.do_rst  = rs;
        r.v       = v;
        r.ordy    = ordy;
        r.exp_rdy = rdy;
        r.exp_ov  = ov;
        r.exp_g   = g;
        vecs.push_back(r);
    endtask

    task automatic drive_data();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data_in[i*WIDTH +: WIDTH] = data_c[i];
            req_dest_in[i*AW +: AW]       = dest_c[i];
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        req_valid_in = '0;
        out_ready_in = 1'b1;
        drive_data();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset_valid", 32'(out_valid_out), 32'd0);
        check("reset_data", out_data_out, 32'd0);
        check("reset_dest", 32'(out_dest_out), 32'd0);
        check("reset_grant", 32'(grant_idx_out), 32'd0);
    endtask

    // Registered-output check for a word expected from requester g.
    task automatic check_word(input string tag, input logic [1:0] g, input logic [31:0] exp_data);
        check({tag, "_valid"}, 32'(out_valid_out), 32'd1);
        check({tag, "_grant"}, 32'(ARB_ID_W'(grant_idx_out)), 32'(ARB_ID_W'(g)));
        check({tag, "_data"}, out_data_out, exp_data);
        check({tag, "_dest"}, 32'(out_dest_out), 32'(dest_c[g]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        req_valid_in = '0;
        out_ready_in = 1'b1;
        data_c       = '{32'h0000_0100, 32'h0000_0201, 32'h0000_000A, 32'h0000_0303};
        dest_c       = '{4'd9, 4'd7, 4'd5, 4'd3};
        drive_data();

        // Single requester 2: same-cycle ready, registered word one cycle later.
        add(1, 4'b0100, 1, 4'b0100, 1, 2'd2);
        // All valid, router always ready: two words per owner, rotating with wrap.
        add(1, 4'b1111, 1, 4'b0001, 1, 2'd0);
        add(0, 4'b1111, 1, 4'b0001, 1, 2'd0);
        add(0, 4'b1111, 1, 4'b0010, 1, 2'd1);
        add(0, 4'b1111, 1, 4'b0010, 1, 2'd1);
        add(0, 4'b1111, 1, 4'b0100, 1, 2'd2);
        add(0, 4'b1111, 1, 4'b0100, 1, 2'd2);
        add(0, 4'b1111, 1, 4'b1000, 1, 2'd3);
        add(0, 4'b1111, 1, 4'b1000, 1, 2'd3);
        add(0, 4'b1111, 1, 4'b0001, 1, 2'd0);
        add(0, 4'b1111, 1, 4'b0001, 1, 2'd0);
        add(0, 4'b0000, 1, 4'b0000, 0, 2'd0);
        // Owner 1 drops after one word; 3 takes over without a bubble, ptr ends at 0.
        add(1, 4'b0010, 1, 4'b0010, 1, 2'd1);
        add(0, 4'b1000, 1, 4'b1000, 1, 2'd3);
        add(0, 4'b1000, 1, 4'b1000, 1, 2'd3);
        add(0, 4'b1111, 1, 4'b0001, 1, 2'd0);
        // Sole requester 3 keeps winning across its burst boundary.
        add(1, 4'b1000, 1, 4'b1000, 1, 2'd3);
        add(0, 4'b1000, 1, 4'b1000, 1, 2'd3);
        add(0, 4'b1000, 1, 4'b1000, 1, 2'd3);
        add(0, 4'b0000, 1, 4'b0000, 0, 2'd0);

        foreach (vecs[n]) begin
            if (vecs[n].do_rst) begin
                do_reset();
            end
            req_valid_in = vecs[n].v;
            out_ready_in = vecs[n].ordy;
            #1;
            check($sformatf("vec%0d_ready", n), 32'(req_ready_out), 32'(vecs[n].exp_rdy));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", n), 32'(out_valid_out), 32'(vecs[n].exp_ov));
            if (vecs[n].exp_ov) begin
                check($sformatf("vec%0d_grant", n), 32'(grant_idx_out), 32'(vecs[n].exp_g));
                check($sformatf("vec%0d_data", n), out_data_out, data_c[vecs[n].exp_g]);
                check($sformatf("vec%0d_dest", n), 32'(out_dest_out), 32'(dest_c[vecs[n].exp_g]));
            end
        end

        // Backpressure: five stalled cycles must not move the output nor spend burst budget.
        do_reset();
        req_valid_in = 4'b1111;
        out_ready_in = 1'b1;
        #1;
        check("bp_first_ready", 32'(req_ready_out), 32'b0001);
        @(posedge clk);
        #1;
        check_word("bp_first", 2'd0, 32'h100);
        out_ready_in              = 1'b0;
        req_data_in[0 +: WIDTH]   = 32'h0000_DEAD;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("bp_stall%0d_ready", c), 32'(req_ready_out), 32'd0);
            @(posedge clk);
            #1;
            check_word($sformatf("bp_stall%0d", c), 2'd0, 32'h100);
        end
        req_data_in[0 +: WIDTH] = 32'h0000_01FF;
        out_ready_in            = 1'b1;
        #1;
        check("bp_resume_ready", 32'(req_ready_out), 32'b0001);
        @(posedge clk);
        #1;
        check_word("bp_second", 2'd0, 32'h1FF);
        #1;
        check("bp_rotate_ready", 32'(req_ready_out), 32'b0010);
        @(posedge clk);
        #1;
        check_word("bp_rotate", 2'd1, 32'h201);
        drive_data();

        // Asynchronous reset mid-burst with a word in the output register.
        do_reset();
        req_valid_in = 4'b1111;
        out_ready_in = 1'b1;
        @(posedge clk);
        #1;
        check("arst_pre_valid", 32'(out_valid_out), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid_out), 32'd0);
        check("arst_data", out_data_out, 32'd0);
        check("arst_grant", 32'(grant_idx_out), 32'd0);
        #1;
        rst = 1'b0;
        #1;
        check("arst_r0_ready", 32'(req_ready_out), 32'b0001);
        @(posedge clk);
        #1;
        check_word("arst_r0", 2'd0, 32'h100);
        #1;
        check("arst_r1_ready", 32'(req_ready_out), 32'b0001);
        @(posedge clk);
        #1;
        check_word("arst_r1", 2'd0, 32'h100);
        #1;
        check("arst_r2_ready", 32'(req_ready_out), 32'b0010);
        @(posedge clk);
        #1;
        check_word("arst_r2", 2'd1, 32'h201);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
